// File: rtl/mux_rr_arbiter.sv
// Purpose : round-robin arbiter driving the select of a shared 4:1 mux, with a
//           per-tenure hold limit so a busy requester cannot starve the others.
// Latency : 1 clock from req to registered gnt/s; handovers are back-to-back.
// Backpressure: none; requesters wait by holding req until gnt arrives.
//
// Ports:
//   clk     - system clock, all state changes on the rising edge
//   rst     - synchronous active-high reset
//   req     - request lines, req[i]=1 means requester i wants the mux
//   gnt     - registered one-hot grant, all-zero when idle
//   s       - registered mux select (binary index of the granted requester)
//   valid   - high while any grant is active (|gnt)
//   preempt - one-cycle pulse after a tenure was cut short by the hold limit
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       valid,
  output logic       preempt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_s;
  logic             r_preempt;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold;

  logic             w_release;
  logic             w_timeout;
  logic             w_end;
  logic             w_any;
  logic [1:0]       w_base;
  logic [1:0]       w_win;

  // First requester at or after base, scanning base, base+1, ... (mod 4).
  // The scan runs from the farthest offset back to base so the nearest wins.
  function automatic logic [1:0] f_pick(input logic [3:0] req_v,
                                        input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] win;
    win = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req_v[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

  always_comb begin
    w_release = ~req[r_s];
    // Timeout only counts while the owner still wants the mux; a release on
    // the limit edge is an ordinary release and does not raise preempt.
    w_timeout = (r_hold == CNT_W'(MAX_HOLD)) & req[r_s];
    w_end     = (r_state == ST_GRANT) & (w_release | w_timeout);
    w_any     = |req;
    // At a tenure end the pointer is about to become owner+1; arbitrate with
    // that value now so the next grant lands on the same edge.
    w_base    = (r_state == ST_GRANT) ? (r_s + 2'd1) : r_ptr;
    w_win     = f_pick(req, w_base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 4'b0000;
      r_s       <= 2'b00;
      r_preempt <= 1'b0;
      r_ptr     <= 2'b00;
      r_hold    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_preempt <= 1'b0;
          if (w_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_s     <= w_win;
            r_hold  <= CNT_W'(1);
          end
        end

        ST_GRANT: begin
          if (w_end) begin
            r_ptr     <= r_s + 2'd1;
            r_preempt <= w_timeout;
            if (w_any) begin
              // A timed-out owner sits last in the new order, so it only
              // wins again when nobody else is asking.
              r_gnt  <= 4'b0001 << w_win;
              r_s    <= w_win;
              r_hold <= CNT_W'(1);
            end else begin
              // s deliberately keeps the last owner's index while idle.
              r_state <= ST_IDLE;
              r_gnt   <= 4'b0000;
              r_hold  <= '0;
            end
          end else begin
            r_preempt <= 1'b0;
            r_hold    <= r_hold + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_gnt     <= 4'b0000;
          r_preempt <= 1'b0;
          r_hold    <= '0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign s       = r_s;
  assign valid   = |r_gnt;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Purpose : self-checking bench for mux_rr_arbiter; a behavioural model feeds
//           a scoreboard queue at each drive edge, popped when outputs settle.
// Latency : outputs sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       valid;
  logic       preempt;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .s       (s),
    .valid   (valid),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       pre;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  bit         m_busy;
  logic [3:0] m_gnt;
  logic [1:0] m_s;
  int         m_ptr;
  int         m_hold;
  bit         m_pre;

  // last observed DUT outputs
  logic [3:0] o_gnt;
  logic [1:0] o_s;
  logic       o_valid;
  logic       o_pre;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_busy = 1'b1;
    m_s    = w[1:0];
    m_gnt  = 4'b0000;
    m_gnt[w] = 1'b1;
    m_hold = 1;
  endtask

  task automatic model_edge(input logic r_rst, input logic [3:0] r_req);
    int w;
    int own;
    if (r_rst) begin
      m_busy = 1'b0; m_gnt = 4'b0000; m_s = 2'b00;
      m_ptr  = 0;    m_hold = 0;      m_pre = 1'b0;
    end else if (!m_busy) begin
      m_pre = 1'b0;
      w = pick(r_req, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      own = int'(m_s);
      if (!r_req[own] || m_hold == MAX_HOLD) begin
        m_pre = r_req[own];
        m_ptr = (own + 1) % 4;
        w = pick(r_req, m_ptr);
        if (w >= 0) begin
          model_grant(w);
        end else begin
          m_busy = 1'b0; m_gnt = 4'b0000; m_hold = 0;
        end
      end else begin
        m_hold++;
        m_pre = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, push the model's prediction, compare after edge.
  task automatic step(input logic r_rst, input logic [3:0] r_req);
    exp_t e;
    rst = r_rst;
    req = r_req;
    @(posedge clk);
    model_edge(r_rst, r_req);
    e.gnt = m_gnt; e.s = m_s; e.valid = m_busy; e.pre = m_pre;
    sb_q.push_back(e);
    @(negedge clk);
    o_gnt = gnt; o_s = s; o_valid = valid; o_pre = preempt;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_gnt",   32'(o_gnt),   32'(e.gnt));
      chk("sb_s",     32'(o_s),     32'(e.s));
      chk("sb_valid", 32'(o_valid), 32'(e.valid));
      chk("sb_pre",   32'(o_pre),   32'(e.pre));
    end
    chk("onehot", 32'($countones(o_gnt) <= 1), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] r;
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);

    // reset with all requesting, then full contention
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    chk("rst_gnt",   32'(o_gnt),   32'd0);
    chk("rst_s",     32'(o_s),     32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pre",   32'(o_pre),   32'd0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b1111);
      exp_g = 4'b0000;
      exp_g[(k / 4) % 4] = 1'b1;
      chk("fc_gnt", 32'(o_gnt), 32'(exp_g));
      chk("fc_s",   32'(o_s),   32'((k / 4) % 4));
      chk("fc_pre", 32'(o_pre), 32'(k > 0 && k % 4 == 0));
    end

    // single request, release, then pointer rotation
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    chk("sr_gnt", 32'(o_gnt), 32'b0100);
    chk("sr_s",   32'(o_s),   32'd2);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("rel_gnt",   32'(o_gnt),   32'd0);
    chk("rel_valid", 32'(o_valid), 32'd0);
    chk("rel_pre",   32'(o_pre),   32'd0);
    chk("rel_s",     32'(o_s),     32'd2);
    step(1'b0, 4'b0011);
    chk("rot_gnt", 32'(o_gnt), 32'b0001);
    chk("rot_s",   32'(o_s),   32'd0);
    step(1'b0, 4'b0010);
    chk("rot2_gnt", 32'(o_gnt), 32'b0010);

    // sole requester keeps the mux across timeouts
    step(1'b1, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0001);
      chk("sole_gnt", 32'(o_gnt), 32'b0001);
      chk("sole_pre", 32'(o_pre), 32'(k > 0 && k % 4 == 0));
    end

    // release on the same edge the hold limit is reached
    step(1'b1, 4'b0000);
    for (int k = 0; k < MAX_HOLD; k++) step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    chk("relto_gnt", 32'(o_gnt), 32'd0);
    chk("relto_pre", 32'(o_pre), 32'd0);
    chk("relto_s",   32'(o_s),   32'd1);

    // reset mid-grant
    step(1'b0, 4'b0100);
    chk("mid_gnt", 32'(o_gnt), 32'b0100);
    step(1'b1, 4'b1111);
    chk("midrst_gnt", 32'(o_gnt), 32'd0);
    step(1'b0, 4'b1111);
    chk("midrst_after", 32'(o_gnt), 32'b0001);

    // random traffic; requests tend to persist so timeouts occur
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 49) == 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 multiplexer datapath among four requesters.
- Sits directly in front of the mux:
  - drives its 2-bit select `s`
  - returns a one-hot grant to the requesters
  - bounds each tenure with a hold limit so no requester starves the others.
- Purely a control block; data does not pass through it.

Parameters:
- MAX_HOLD, default 4: maximum consecutive cycles one requester may hold the mux. Must be ≥ 1.
- CNT_W, default 3: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk      input   1  single system clock; all state updates on rising edge
- rst      input   1  synchronous reset, active-high
- req      input   4  request lines; req[i] high = requester i wants the mux
- gnt      output  4  one-hot grant, registered; all-zero when idle
- s        output  2  mux select, registered; binary index of granted requester
- valid    output  1  high while any grant is active (equals |gnt)
- preempt  output  1  one-cycle pulse: previous grant was ended by MAX_HOLD expiry

Behaviour:
- Reset (rst sampled high at an edge):
  - state=IDLE, gnt=0000, s=00, valid=0, preempt=0
  - priority pointer ptr=0, hold_cnt=0
  - Reset overrides all other activity, including mid-grant.
- Priority order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with req high wins.
- State IDLE:
  - If req==0000, remain in IDLE; gnt=0000, valid=0, s holds its last value.
  - If any req bit is high, at the next edge: state=GRANT, gnt=onehot(winner), s=winner, valid=1, hold_cnt=1.
  - Latency from req rising to gnt is 1 clock.
- State GRANT (current owner cur), evaluated each edge:
  - Release: req[cur]==0 ends the tenure. gnt stays high during the cycle req[cur] is low and drops at that edge. preempt=0.
  - Timeout: hold_cnt==MAX_HOLD with req[cur] still high ends the tenure. gnt is therefore high for exactly MAX_HOLD cycles. preempt=1 for the following cycle only.
  - Release and timeout on the same edge are treated as release (preempt=0).
  - Otherwise: hold_cnt increments, gnt/s unchanged, preempt=0.
- On tenure end:
  - ptr <= (cur+1) mod 4, with wrap 3→0.
  - Arbitration reruns immediately with the new ptr. If any req is high, a new grant is issued at the same edge (back-to-back, no idle gap), with hold_cnt=1.
  - A timed-out owner has lowest priority, so it is re-granted only if it is the sole requester.
  - If no req is high, go to IDLE: gnt=0000, valid=0, s holds.
- Non-owner requests changing mid-tenure have no effect until the tenure ends.
- gnt is always zero-hot or one-hot. s always equals the encoded gnt whenever valid=1.
- hold_cnt never exceeds MAX_HOLD and saturates by construction.

Test Plan:
- Reset: rst=1 for 2 edges with req=1111 → gnt=0000, s=00, valid=0, preempt=0. First edge after rst=0 → gnt=0001, s=00.
- Single request with release:
  - req=0100 from cycle 0 → gnt=0100, s=10, valid=1 after 1 edge.
  - Drop req after 2 grant cycles → gnt=0000, valid=0 at the following edge, preempt=0, s stays 10.
- Full contention, MAX_HOLD=4, req=1111 held:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, each for exactly 4 cycles.
  - s sequence 00, 01, 10, 11, 00.
  - preempt pulses once per handover; no idle cycle between grants.
- Sole requester timeout: req=0001 held → gnt=0001 for 4 cycles, preempt=1 for 1 cycle, gnt stays 0001 continuously (re-granted back-to-back), hold_cnt restarts at 1.
- Pointer rotation:
  - Requester 2 granted, then released (ptr becomes 3).
  - Apply req=0011 → gnt=0001, s=00 (order 3, 0, 1, 2).
  - Release → next grant 0010.
- Reset mid-grant and edge cases:
  - rst pulsed while gnt=0100 → gnt=0000 at that edge. With req=1111 afterwards → gnt=0001 (ptr back to 0).
  - Release on the same edge as hold_cnt==MAX_HOLD → preempt stays 0.
